// File: rtl/multi_square_wave_gen_if.sv
// Bus bundle for multi_square_wave_gen.
//   en          per-channel run enable (level)
//   load        strobe: capture on/off periods of all channels into shadow regs
//   on_period   channel i at [i*W +: W], high-phase length in base ticks
//   off_period  channel i at [i*W +: W], low-phase length in base ticks
//   signal      registered square-wave outputs
//   cycle_tick  1-clk pulse in the first clk of each HIGH phase
// master drives the controls; slave is the generator.
interface multi_square_wave_gen_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  logic [N_CH-1:0]   en;
  logic              load;
  logic [N_CH*W-1:0] on_period;
  logic [N_CH*W-1:0] off_period;
  logic [N_CH-1:0]   signal;
  logic [N_CH-1:0]   cycle_tick;

  modport master (
    output en, load, on_period, off_period,
    input  signal, cycle_tick
  );

  modport slave (
    input  en, load, on_period, off_period,
    output signal, cycle_tick
  );
endinterface

// File: rtl/multi_square_wave_gen.sv
// N-channel programmable square/PWM generator with one shared prescaler.
// Each channel keeps its own double-buffered on/off periods; the shadow copy
// becomes active only at a cycle start, so a new config never cuts a phase.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    multi_square_wave_gen_if.slave (en, load, periods in; signal, cycle_tick out)
//
// state | meaning
// IDLE  | channel disabled, output low, waiting for en at a base tick
// HIGH  | high phase, cnt counts base ticks up to act_on-1
// LOW   | low phase, cnt counts base ticks up to act_off-1
module multi_square_wave_gen #(
  parameter int N_CH        = 4,
  parameter int W           = 8,
  parameter int BASE_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_square_wave_gen_if.slave bus
);
  localparam int PW = (BASE_CYCLES > 1) ? $clog2(BASE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic [PW-1:0]          base_cnt_q, base_cnt_d;
  logic                   base_tick;
  logic [N_CH-1:0][W-1:0] shadow_on_q, shadow_on_d;
  logic [N_CH-1:0][W-1:0] shadow_off_q, shadow_off_d;
  logic [N_CH-1:0][W-1:0] act_on_q, act_on_d;
  logic [N_CH-1:0][W-1:0] act_off_q, act_off_d;
  logic [N_CH-1:0][W-1:0] cnt_q, cnt_d;
  state_t                 state_q [N_CH];
  state_t                 state_d [N_CH];
  logic [N_CH-1:0]        signal_q, signal_d;
  logic [N_CH-1:0]        cycle_tick_q, cycle_tick_d;
  logic [N_CH-1:0]        cycle_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_cnt_q   <= '0;
      shadow_on_q  <= '0;
      shadow_off_q <= '0;
      act_on_q     <= '0;
      act_off_q    <= '0;
      cnt_q        <= '0;
      signal_q     <= '0;
      cycle_tick_q <= '0;
      for (int i = 0; i < N_CH; i++) state_q[i] <= IDLE;
    end else begin
      base_cnt_q   <= base_cnt_d;
      shadow_on_q  <= shadow_on_d;
      shadow_off_q <= shadow_off_d;
      act_on_q     <= act_on_d;
      act_off_q    <= act_off_d;
      cnt_q        <= cnt_d;
      signal_q     <= signal_d;
      cycle_tick_q <= cycle_tick_d;
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    base_tick  = (base_cnt_q == PW'(BASE_CYCLES - 1));
    base_cnt_d = base_tick ? '0 : base_cnt_q + PW'(1);

    shadow_on_d  = shadow_on_q;
    shadow_off_d = shadow_off_q;
    if (bus.load) begin
      shadow_on_d  = bus.on_period;
      shadow_off_d = bus.off_period;
    end

    act_on_d     = act_on_q;
    act_off_d    = act_off_q;
    cnt_d        = cnt_q;
    signal_d     = signal_q;
    cycle_tick_d = '0;
    cycle_start  = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      // Disable is immediate, not aligned to the prescaler.
      if (!bus.en[i]) begin
        state_d[i]  = IDLE;
        cnt_d[i]    = '0;
        signal_d[i] = 1'b0;
      end else if (base_tick) begin
        case (state_q[i])
          IDLE: cycle_start[i] = 1'b1;
          HIGH: begin
            if (cnt_q[i] == act_on_q[i] - W'(1)) begin
              if (act_off_q[i] != '0) begin
                state_d[i]  = LOW;
                cnt_d[i]    = '0;
                signal_d[i] = 1'b0;
              end else begin
                cycle_start[i] = 1'b1;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + W'(1);
            end
          end
          LOW: begin
            if (act_off_q[i] == '0 || cnt_q[i] == act_off_q[i] - W'(1)) begin
              cycle_start[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + W'(1);
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end

      // Uses the registered shadow, so a load on this same edge waits one cycle.
      if (cycle_start[i]) begin
        act_on_d[i]  = shadow_on_q[i];
        act_off_d[i] = shadow_off_q[i];
        cnt_d[i]     = '0;
        if (shadow_on_q[i] != '0) begin
          state_d[i]      = HIGH;
          signal_d[i]     = 1'b1;
          cycle_tick_d[i] = 1'b1;
        end else begin
          state_d[i]  = LOW;
          signal_d[i] = 1'b0;
        end
      end
    end
  end

  assign bus.signal     = signal_q;
  assign bus.cycle_tick = cycle_tick_q;
endmodule

// File: tb/tb_multi_square_wave_gen.sv
module tb_multi_square_wave_gen;
  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int BC   = 10;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  multi_square_wave_gen_if #(.N_CH(N_CH), .W(W)) bus ();

  multi_square_wave_gen #(.N_CH(N_CH), .W(W), .BASE_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the current cycle in base ticks.
  // signal is high while pos < on; the cycle restarts once pos reaches on+off.
  int              m_bc;
  bit              m_run [N_CH];
  int              m_pos [N_CH];
  int              m_aon [N_CH];
  int              m_aoff[N_CH];
  int              m_son [N_CH];
  int              m_soff[N_CH];
  logic [N_CH-1:0] exp_sig;
  logic [N_CH-1:0] exp_tick;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, want);
    end
  endtask

  task automatic model_reset();
    m_bc = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_aon[i] = 0; m_aoff[i] = 0;
      m_son[i] = 0; m_soff[i] = 0;
    end
    exp_sig  = '0;
    exp_tick = '0;
  endtask

  task automatic model_edge();
    bit tick;
    bit started;
    int len;
    tick = (m_bc == BC - 1);
    for (int i = 0; i < N_CH; i++) begin
      started = 0;
      if (!bus.en[i]) begin
        m_run[i] = 0;
        m_pos[i] = 0;
      end else if (tick) begin
        if (!m_run[i]) begin
          started = 1;
        end else begin
          m_pos[i]++;
          len = m_aon[i] + m_aoff[i];
          if (len == 0) len = 1;
          if (m_pos[i] >= len) started = 1;
        end
      end
      if (started) begin
        m_aon[i]  = m_son[i];
        m_aoff[i] = m_soff[i];
        m_pos[i]  = 0;
        m_run[i]  = 1;
      end
      exp_sig[i]  = m_run[i] && (m_pos[i] < m_aon[i]);
      exp_tick[i] = started && (m_aon[i] != 0);
    end
    if (bus.load) begin
      for (int i = 0; i < N_CH; i++) begin
        m_son[i]  = int'(bus.on_period[i*W +: W]);
        m_soff[i] = int'(bus.off_period[i*W +: W]);
      end
    end
    m_bc = (m_bc == BC - 1) ? 0 : m_bc + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("signal", 32'(bus.signal), 32'(exp_sig));
    check_eq("cycle_tick", 32'(bus.cycle_tick), 32'(exp_tick));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_ch(input int ch, input int on, input int off);
    bus.on_period[ch*W +: W]  = W'(on);
    bus.off_period[ch*W +: W] = W'(off);
  endtask

  task automatic do_load();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic wait_high(input int ch, input int budget, input string tag);
    int k;
    k = 0;
    while (!bus.signal[ch] && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(bus.signal[ch]), 32'd1);
  endtask

  initial begin
    int rise_n;
    n_cmp = 0;
    n_err = 0;
    bus.en = '0; bus.load = 1'b0; bus.on_period = '0; bus.off_period = '0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_signal", 32'(bus.signal), 32'd0);
    check_eq("rst_tick", 32'(bus.cycle_tick), 32'd0);
    reset = 1'b0;

    // 3/2 on ch0, first rise within BASE_CYCLES+1 clk of en
    set_ch(0, 3, 2);
    do_load();
    bus.en[0] = 1'b1;
    rise_n = 0;
    while (!bus.signal[0] && rise_n < 30) begin
      step();
      rise_n++;
    end
    check_eq("t1_first_rise_le11", 32'(rise_n <= BC + 1), 32'd1);
    run(200);

    // mid-HIGH reload to 10/10
    wait_high(0, 60, "t2_wait_high");
    run(5);
    set_ch(0, 10, 10);
    do_load();
    run(500);
    bus.en = '0;
    run(3);

    // zero periods: 0/5, 5/0, 0/0
    set_ch(0, 0, 5); set_ch(1, 5, 0); set_ch(2, 0, 0);
    do_load();
    bus.en = 4'b0111;
    run(300);
    bus.en = '0;
    run(3);

    // all four channels, drop and re-raise en[1]
    set_ch(0, 1, 1); set_ch(1, 2, 3); set_ch(2, 4, 4); set_ch(3, 7, 1);
    do_load();
    bus.en = 4'b1111;
    run(40);
    wait_high(1, 80, "t4_wait_high");
    run(3);
    bus.en[1] = 1'b0;
    step();
    check_eq("t4_drop_low", 32'(bus.signal[1]), 32'd0);
    run(57);
    bus.en[1] = 1'b1;
    run(300);
    bus.en = '0;
    run(3);

    // max periods on ch3
    set_ch(3, 255, 255);
    do_load();
    bus.en[3] = 1'b1;
    run(5300);
    bus.en = '0;
    run(3);

    // randomized configs, enables and loads
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < N_CH; c++) set_ch(c, $urandom_range(0, 6), $urandom_range(0, 6));
      bus.load = $urandom_range(0, 1);
      bus.en   = N_CH'($urandom);
      for (int k = 0; k < 150; k++) begin
        step();
        bus.load = 1'b0;
        if ($urandom_range(0, 19) == 0) bus.en[$urandom_range(0, N_CH-1)] ^= 1'b1;
        if ($urandom_range(0, 29) == 0) begin
          set_ch($urandom_range(0, N_CH-1), $urandom_range(0, 6), $urandom_range(0, 6));
          bus.load = 1'b1;
        end
      end
    end
    bus.load = 1'b0;
    bus.en = '0;
    run(3);

    // asynchronous reset mid-HIGH, then no shadow after release
    set_ch(0, 5, 5);
    do_load();
    bus.en[0] = 1'b1;
    wait_high(0, 40, "t6_wait_high");
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_async_signal", 32'(bus.signal), 32'd0);
    check_eq("t6_async_tick", 32'(bus.cycle_tick), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.en = '1;
    run(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
